// File: rtl/decode_bundle_pkg.sv
// Shared definitions for the decode stage: immediate-type codes, opcode
// constants, issue-queue codes, priority encoding, field widths and the
// immediate helper functions used by decode_slot.
package decode_bundle_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 7;
  localparam int REG_W   = 5;
  localparam int REGS_W  = 3 * REG_W;
  localparam int FUNC_W  = 10;
  localparam int CTRL_W  = 5;
  localparam int IMM_W   = 32;

  typedef enum logic [2:0] {
    NT = 3'd0,  // unknown opcode
    RT = 3'd1,
    IT = 3'd2,
    ST = 3'd3,
    BT = 3'd4,
    UT = 3'd5,
    JT = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    MEMQ = 2'b01,
    ALUQ = 2'b10
  } queue_e;

  localparam logic [1:0] PRY_NORM = 2'b00;
  localparam logic [1:0] PRY_BR   = 2'b11;

  // Immediate format selected by the major opcode.
  function automatic imm_type_e InstrDecoder(input logic [6:0] opc);
    imm_type_e t;
    case (opc)
      OPC_OP:                        t = RT;
      OPC_LOAD, OPC_OPIMM, OPC_JALR: t = IT;
      OPC_STORE:                     t = ST;
      OPC_BRANCH:                    t = BT;
      OPC_LUI, OPC_AUIPC:            t = UT;
      OPC_JAL:                       t = JT;
      default:                       t = NT;
    endcase
    return t;
  endfunction

  // Replicate bit msb of val into every higher bit position.
  function automatic logic [31:0] signExtend(input logic [31:0] val, input logic [4:0] msb);
    logic [31:0] res;
    for (int i = 0; i < 32; i++) begin
      res[i] = (i <= int'(msb)) ? val[i] : val[msb];
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_bundle_slot.sv
// Combinational single-instruction decoder (module decode_slot).
// Optional feature macro: DECODE_SHIFT_IMM_EN keeps funct7 for immediate
// shifts so SRAI and SRLI decode to different func values.
module decode_slot
  import decode_bundle_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               valid_i,
  output logic [OPC_W-1:0]   uop_o,
  output logic [REGS_W-1:0]  regs_o,
  output logic [FUNC_W-1:0]  func_o,
  output logic [CTRL_W-1:0]  ctrl_o,
  output logic [IMM_W-1:0]   imm_o
);

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  imm_type_e  itype;
  logic [1:0] pry;
  logic [1:0] queue;

  assign opc   = instr_i[6:0];
  assign rd    = instr_i[11:7];
  assign f3    = instr_i[14:12];
  assign rs1   = instr_i[19:15];
  assign rs2   = instr_i[24:20];
  assign f7    = instr_i[31:25];
  assign itype = InstrDecoder(opc);

  // Field decode by format; a masked slot forces every field to zero.
  always_comb begin
    uop_o  = '0;
    regs_o = '0;
    func_o = '0;
    ctrl_o = '0;
    imm_o  = '0;
    pry    = PRY_NORM;
    queue  = ALUQ;
    if (valid_i) begin
      case (itype)
        RT: begin
          regs_o = {rd, rs2, rs1};
          func_o = {f7, f3};
        end
        IT: begin
          regs_o = {rd, 5'd0, rs1};
          func_o = {7'd0, f3};
`ifdef DECODE_SHIFT_IMM_EN
          if (opc == OPC_OPIMM && (f3 == 3'b001 || f3 == 3'b101)) begin
            func_o = {f7, f3};
          end
`endif
          imm_o = signExtend({20'd0, instr_i[31:20]}, 5'd11);
        end
        ST: begin
          regs_o = {5'd0, rs2, rs1};
          func_o = {7'd0, f3};
          imm_o  = signExtend({20'd0, instr_i[31:25], instr_i[11:7]}, 5'd11);
        end
        BT: begin
          regs_o = {5'd0, rs2, rs1};
          func_o = {7'd0, f3};
          imm_o  = signExtend({19'd0, instr_i[31], instr_i[7], instr_i[30:25],
                               instr_i[11:8], 1'b0}, 5'd12);
        end
        UT: begin
          regs_o = {rd, 10'd0};
          imm_o  = {instr_i[31:12], 12'd0};
        end
        JT: begin
          regs_o = {rd, 10'd0};
          imm_o  = signExtend({11'd0, instr_i[31], instr_i[19:12], instr_i[20],
                               instr_i[30:21], 1'b0}, 5'd20);
        end
        default: ;
      endcase
      if (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_JALR) pry = PRY_BR;
      if (opc[6] == 1'b0 && opc[4:0] == 5'b00011) queue = MEMQ;
      uop_o  = opc;
      ctrl_o = {pry, queue, 1'b1};
    end
  end

endmodule

// File: rtl/decode_bundle.sv
// Registered DEC_WIDTH-wide decode stage with branch-tag allocation.
// Optional feature macro: DECODE_SHIFT_IMM_EN (see decode_slot).
//
// Handshake: a bundle moves on a cycle where valid and ready are both high on
// that side. Input side: accept = i_valid && o_ready; o_ready never depends on
// i_valid. Output side: the held bundle is consumed when o_valid && i_ready and
// stays stable (except brmask bits released by i_br_free) until then.
module decode_bundle
  import decode_bundle_pkg::*;
#(
  parameter int DEC_WIDTH = 2,
  parameter int WIDTH_BRM = 6
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [INSTR_W*DEC_WIDTH-1:0]   i_instr,
  input  logic [DEC_WIDTH-1:0]           i_imask,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [OPC_W*DEC_WIDTH-1:0]     o_uop,
  output logic [REGS_W*DEC_WIDTH-1:0]    o_regs,
  output logic [FUNC_W*DEC_WIDTH-1:0]    o_func,
  output logic [CTRL_W*DEC_WIDTH-1:0]    o_ctrl,
  output logic [IMM_W*DEC_WIDTH-1:0]     o_imm,
  output logic [WIDTH_BRM*DEC_WIDTH-1:0] o_brtag,
  output logic [WIDTH_BRM*DEC_WIDTH-1:0] o_brmask,
  input  logic [WIDTH_BRM-1:0]           i_br_free,
  input  logic                           i_flush
);

  logic [DEC_WIDTH-1:0][OPC_W-1:0]     uop_c, uop_d, uop_q;
  logic [DEC_WIDTH-1:0][REGS_W-1:0]    regs_c, regs_d, regs_q;
  logic [DEC_WIDTH-1:0][FUNC_W-1:0]    func_c, func_d, func_q;
  logic [DEC_WIDTH-1:0][CTRL_W-1:0]    ctrl_c, ctrl_d, ctrl_q;
  logic [DEC_WIDTH-1:0][IMM_W-1:0]     imm_c, imm_d, imm_q;
  logic [DEC_WIDTH-1:0][WIDTH_BRM-1:0] brtag_c, brtag_d, brtag_q;
  logic [DEC_WIDTH-1:0][WIDTH_BRM-1:0] brmask_c, brmask_d, brmask_q;
  logic [DEC_WIDTH-1:0]                is_br;

  logic [WIDTH_BRM-1:0] alloc_q, alloc_d;
  logic [WIDTH_BRM-1:0] avail, older, grant;
  logic [7:0]           free_cnt, br_cnt;
  logic                 found;
  logic                 valid_q, valid_d;
  logic                 accept;

  for (genvar s = 0; s < DEC_WIDTH; s++) begin : g_slot
    decode_slot u_slot (
      .instr_i (i_instr[s*INSTR_W +: INSTR_W]),
      .valid_i (i_imask[s]),
      .uop_o   (uop_c[s]),
      .regs_o  (regs_c[s]),
      .func_o  (func_c[s]),
      .ctrl_o  (ctrl_c[s]),
      .imm_o   (imm_c[s])
    );
    assign is_br[s] = ctrl_c[s][0] && (ctrl_c[s][4:3] == PRY_BR);
  end

  // Grant lowest free tags to branch slots in age order and build older-branch masks.
  always_comb begin
    avail    = ~alloc_q;
    older    = alloc_q;
    grant    = '0;
    free_cnt = '0;
    br_cnt   = '0;
    found    = 1'b0;
    brtag_c  = '0;
    brmask_c = '0;
    for (int b = 0; b < WIDTH_BRM; b++) begin
      free_cnt = free_cnt + 8'(!alloc_q[b]);
    end
    for (int s = 0; s < DEC_WIDTH; s++) begin
      found = 1'b0;
      if (is_br[s]) begin
        br_cnt = br_cnt + 8'd1;
        for (int b = 0; b < WIDTH_BRM; b++) begin
          if (!found && avail[b]) begin
            brtag_c[s][b] = 1'b1;
            found         = 1'b1;
          end
        end
      end
      if (i_imask[s]) brmask_c[s] = older;
      avail = avail & ~brtag_c[s];
      older = older | brtag_c[s];
      grant = grant | brtag_c[s];
    end
  end

  // Handshake: accept only when the output slot frees up and enough tags are free.
  always_comb begin
    o_ready = !i_flush && (!valid_q || i_ready) && (free_cnt >= br_cnt);
    accept  = i_valid && o_ready;
  end

  // Next state of the output register and the tag allocator.
  always_comb begin
    valid_d  = accept || (valid_q && !i_ready && !i_flush);
    alloc_d  = (alloc_q & ~i_br_free) | (accept ? grant : '0);
    uop_d    = accept ? uop_c   : uop_q;
    regs_d   = accept ? regs_c  : regs_q;
    func_d   = accept ? func_c  : func_q;
    ctrl_d   = accept ? ctrl_c  : ctrl_q;
    imm_d    = accept ? imm_c   : imm_q;
    brtag_d  = accept ? brtag_c : brtag_q;
    for (int s = 0; s < DEC_WIDTH; s++) begin
      brmask_d[s] = (accept ? brmask_c[s] : brmask_q[s]) & ~i_br_free;
    end
  end

  // State registers; reset clears the held bundle and frees every tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      alloc_q  <= '0;
      uop_q    <= '0;
      regs_q   <= '0;
      func_q   <= '0;
      ctrl_q   <= '0;
      imm_q    <= '0;
      brtag_q  <= '0;
      brmask_q <= '0;
    end else begin
      valid_q  <= valid_d;
      alloc_q  <= alloc_d;
      uop_q    <= uop_d;
      regs_q   <= regs_d;
      func_q   <= func_d;
      ctrl_q   <= ctrl_d;
      imm_q    <= imm_d;
      brtag_q  <= brtag_d;
      brmask_q <= brmask_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_uop    = uop_q;
  assign o_regs   = regs_q;
  assign o_func   = func_q;
  assign o_ctrl   = ctrl_q;
  assign o_imm    = imm_q;
  assign o_brtag  = brtag_q;
  assign o_brmask = brmask_q;

endmodule
